// File: rtl/bcd_countdown.sv
// Loadable multi-digit BCD down-counter with start/pause control, optional
// auto-reload and a one-cycle done pulse on expiry.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | loaded or reset, waiting for start; ticks ignored
// RUN      | counting down on each tick
// PAUSED   | count frozen until start
// EXPIRED  | reached zero (no auto-reload); start reloads from reload_reg
module bcd_countdown #(
  parameter int DIGITS      = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic [1:0]            state,
  output logic                  busy,
  output logic                  zero,
  output logic                  done,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] CNT_ZERO = '0;
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_EXPIRED = 2'b11
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] reload_q, reload_d;
  logic         done_q, done_d;
  logic         load_err_q, load_err_d;

  logic [W-1:0] load_san;
  logic         load_bad;
  logic [W-1:0] count_dec;
  logic         count_is_zero;
  logic         count_is_one;
  logic         reload_is_zero;

  // Out-of-range digits are clamped to 9 so count always holds valid BCD.
  always_comb begin
    load_san = load_val;
    load_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_san[4*i +: 4] = 4'd9;
        load_bad           = 1'b1;
      end
    end
  end

  // Digit-serial borrow: zero digits wrap to 9 until a nonzero digit absorbs it.
  always_comb begin
    logic borrow;
    count_dec = count_q;
    borrow    = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          count_dec[4*i +: 4] = 4'd9;
        end else begin
          count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow              = 1'b0;
        end
      end
    end
  end

  assign count_is_zero  = (count_q == CNT_ZERO);
  assign count_is_one   = (count_q == CNT_ONE);
  assign reload_is_zero = (reload_q == CNT_ZERO);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    done_d     = 1'b0;
    load_err_d = load_err_q;

    if (load) begin
      count_d    = load_san;
      reload_d   = load_san;
      load_err_d = load_bad;
      state_d    = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (count_is_zero) begin
              state_d = ST_EXPIRED;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end

        ST_RUN: begin
          // start outranks pause/tick and has no effect while running
          if (start) begin
            state_d = ST_RUN;
          end else if (pause) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            if (count_is_zero) begin
              count_d = reload_q;
              done_d  = reload_is_zero;
            end else if (count_is_one) begin
              count_d = CNT_ZERO;
              done_d  = 1'b1;
              state_d = AUTO_RELOAD ? ST_RUN : ST_EXPIRED;
            end else begin
              count_d = count_dec;
            end
          end
        end

        ST_PAUSED: begin
          if (start) begin
            state_d = ST_RUN;
          end
        end

        ST_EXPIRED: begin
          if (start) begin
            count_d = reload_q;
            if (reload_is_zero) begin
              done_d = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      count_q    <= CNT_ZERO;
      reload_q   <= CNT_ZERO;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign state    = state_q;
  assign done     = done_q;
  assign load_err = load_err_q;
  assign busy     = (state_q == ST_RUN);
  assign zero     = count_is_zero;

endmodule

// File: doc/bcd_countdown.md
Name: bcd_countdown

Overview:
- Loadable multi-digit BCD down-counter, the count-down counterpart of the team's decade up-counter. Each digit goes 9,8,...,0, then borrows from the next digit.
- Decrements only on a one-cycle tick strobe from an external prescaler.
- Provides a start/pause control FSM, an optional auto-reload periodic mode and a one-cycle done pulse on expiry.
- Feeds display/timeout logic that needs a decimal countdown value.

Parameters:
- DIGITS, 4, number of BCD digits; count width is 4*DIGITS.
- AUTO_RELOAD, 0, 1 = on reaching zero, reload from the reload register and keep running; 0 = stop at zero.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  load load_val into count and the reload register.
- load_val  in  4*DIGITS  BCD value to load; digit i is bits [4i+3:4i].
- start  in  1  start or resume counting.
- pause  in  1  pause counting.
- tick  in  1  decrement strobe, one clk wide.
- count  out  4*DIGITS  current BCD value (registered).
- state  out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 EXPIRED (registered).
- busy  out  1  state==RUN (combinational from state).
- zero  out  1  count==0 (combinational from count).
- done  out  1  one-cycle pulse on expiry (registered).
- load_err  out  1  last load had a digit >9 (sticky until next load).

Behaviour:
- Reset (async, while rst=1): count=0, reload_reg=0, state=IDLE, done=0, load_err=0; therefore zero=1 and busy=0. Reset mid-run aborts immediately; no done pulse.
- Load sanitising: any digit >9 is clamped to 9. load_err is set if any digit was >9, cleared otherwise.
- Input priority per cycle: load > start > pause > tick.
- done defaults to 0 every cycle; it is 1 only in the cycle after an expiry or retrigger event.
- load (any state): count <= sanitised load_val; reload_reg <= same; state <= IDLE; done <= 0.
- IDLE:
  - start with count!=0 -> RUN.
  - start with count==0 -> EXPIRED and done pulse.
  - tick is ignored.
- RUN:
  - pause -> PAUSED; a tick in the same cycle is ignored.
  - tick with count>1: BCD decrement. Lowest digit -1 if nonzero; otherwise it becomes 9 and the borrow ripples to the next digit. Example: 0100 -> 0099.
  - tick with count==1: count <= 0, done <= 1. If AUTO_RELOAD=0 the state goes to EXPIRED; if AUTO_RELOAD=1 it stays RUN.
  - tick with count==0 (only possible when AUTO_RELOAD=1): count <= reload_reg, no done. Period is reload_reg+1 ticks.
  - AUTO_RELOAD=1 with reload_reg==0: on a tick at count==0, count stays 0, done pulses every tick, state stays RUN.
  - start while in RUN: no effect.
- PAUSED:
  - count frozen; ticks ignored.
  - start -> RUN, effective next cycle; a tick in the same cycle as start is ignored.
  - pause is a no-op.
- EXPIRED:
  - count holds 0; ticks ignored.
  - start: count <= reload_reg. Next state is RUN if reload_reg!=0; otherwise stay EXPIRED with another done pulse.
- Latency: count, state and done update on the clk edge that samples tick/start/load; there is no further pipelining.
- Arithmetic: purely BCD. count is always a valid BCD value; no binary intermediate is exposed. Underflow below 0 is impossible by construction.

Test Plan:
- Reset: assert rst asynchronously mid-cycle while RUN with count=0042 -> count=0000, state=00, done=0, zero=1 immediately, without waiting for a clock edge.
- Borrow chain: load 1000, start, 1 tick -> 0999; 999 more ticks -> 0000, done high exactly one cycle, state=11; extra ticks leave count at 0000.
- Pause/resume: load 0005, start, 2 ticks -> 0003. Pause asserted with tick in the same cycle -> count stays 0003, state=10. 3 ticks -> still 0003. Start, then 3 ticks -> 0000, done pulse.
- Load error: load_val 0x0A9F -> count=0999, load_err=1, state=00. Next load 0x0012 -> load_err=0.
- Auto-reload (AUTO_RELOAD=1): load 0002, start, 9 ticks -> count sequence 1,0,2,1,0,2,1,0,2. done pulses after ticks 2, 5 and 8; state stays 01.
- Start at zero: load 0000, start -> state=11, done pulse. Start again -> done pulses again, state stays 11. Load during RUN with value 0007 -> count=0007, state=00, no done pulse.
